au_driver: RTL and testbench
============================

# au_driver

Sequential initiator for the 32-bit arithmetic unit (add/sub/mult/div with hi/lo result registers and zero flag). Accepts one operation at a time from a host over a valid/ready request channel. Initializes the arithmetic unit through its active-low init input, drives stable operands and opcode, and waits a parameterized number of cycles for the result. It then captures s/hi/lo/zero and returns them over a valid/ready response channel. Divide-by-zero is trapped locally and never issued.

## Interface
Parameters:
- ADD_CYCLES, 1: cycles the unit needs for an ADD/SUB result to be valid (>=1).
- MD_CYCLES, 33: cycles after the init pulse for MULT/DIV hi/lo to be valid (>=1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_a, req_b  in  32 each  operands.
- req_op  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_hi, rsp_lo  out  32 each  result; see Operation.
- rsp_zero  out  1  registered zero flag.
- rsp_err  out  1  divide by zero.
- au_a, au_b  out  32 each  operands to unit.
- au_op  out  2  opcode to unit.
- au_rst_n  out  1  active-low init to unit.
- au_s, au_hi, au_lo  in  32 each  unit results.
- au_zero  in  1  unit zero flag.

## Operation
- States: IDLE, INIT, RUN, RESP.
- IDLE: req_ready=1. On req_valid, latch req_a/req_b/req_op into au_a/au_b/au_op. These hold unchanged until the response handshake completes.
- From IDLE:
  - DIV with req_b==0 goes to RESP directly with rsp_err=1, rsp_hi=req_a, rsp_lo=32'hFFFFFFFF, rsp_zero=0. No INIT and no au_rst_n pulse.
  - ADD/SUB goes to RUN with counter=ADD_CYCLES.
  - MULT/DIV goes to INIT.
- INIT: exactly one cycle with au_rst_n=0, then RUN with counter=MD_CYCLES. au_rst_n is 1 in every other state.
- RUN: counter decrements each cycle. In the cycle where counter==1, capture results on the edge and go to RESP.
  - ADD/SUB: rsp_lo=au_s, rsp_hi=0.
  - MULT/DIV: rsp_hi=au_hi, rsp_lo=au_lo. For DIV, hi is the remainder and lo the quotient.
  - All ops: rsp_zero=au_zero, rsp_err=0.
- Counter width is $clog2(max(ADD_CYCLES,MD_CYCLES)+1). No wrap: the counter is reloaded only on entry to RUN.
- RESP: rsp_valid=1, and rsp_* are held stable while rsp_ready=0. On rsp_valid&&rsp_ready, go to IDLE.
- req_valid outside IDLE is ignored. Requests are not queued.
- Reset values:
  - state IDLE, req_ready=1.
  - rsp_valid=0, rsp_hi/lo=0, rsp_zero=0, rsp_err=0.
  - au_a/au_b=0, au_op=00.
  - au_rst_n=0 while rst is high; it goes to 1 on the first clk edge after rst deasserts.
- Reset mid-operation abandons the operation with no response. au_rst_n is held 0 during reset, which re-initializes the unit.

## Timing
- Request accepted on edge T (req_valid&&req_ready sampled).
- rsp_valid first high in cycle:
  - ADD/SUB: T+ADD_CYCLES+1.
  - MULT/DIV: T+MD_CYCLES+2.
  - Divide-by-zero: T+1.
- For MULT/DIV, au_rst_n is low in cycle T+1 only.
- Response accepted on edge R: rsp_valid=0 and req_ready=1 from cycle R+1. Back-to-back throughput is one op per latency+1 cycles.
- req_ready is deasserted from cycle T+1 until return to IDLE.

## Test plan
With ADD_CYCLES=1 and MD_CYCLES=33, and a behavioural unit model that has the matching latencies:
- ADD a=5, b=7, rsp_ready=1 -> rsp_valid at T+2 with lo=12, hi=0, zero=0, err=0. au_rst_n stays 1 throughout.
- SUB a=9, b=9 -> lo=0, zero=1 at T+2. Then SUB a=0, b=1 -> lo=32'hFFFFFFFF, zero=0.
- MULT a=32'h00010000, b=32'h00010000 -> au_rst_n=0 in cycle T+1 only; rsp_valid at T+35 with hi=1, lo=0, zero=0.
- DIV a=100, b=7 -> lo=14, hi=2 at T+35. DIV a=42, b=0 -> rsp_valid at T+1 with err=1, hi=42, lo=32'hFFFFFFFF, and no au_rst_n pulse.
- Backpressure and busy:
  - Hold rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready=0.
  - Pulse req_valid with different operands during RUN -> ignored, and au_a/au_b unchanged.
  - Raise rsp_ready -> req_ready=1 the next cycle.
- Assert rst in cycle T+10 of a MULT -> all outputs take reset values immediately (asynchronous) and au_rst_n=0. After release: IDLE, no rsp_valid, and a new ADD 1+1 returns lo=2 at T'+2.

Source files
------------

// File: rtl/au_driver.sv
// rtl/au_driver.sv - sequential initiator for the 32-bit add/sub/mult/div arithmetic unit
module au_driver #(
    parameter int ADD_CYCLES = 1,
    parameter int MD_CYCLES  = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_hi,
    output logic [31:0] rsp_lo,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [31:0] au_a,
    output logic [31:0] au_b,
    output logic [1:0]  au_op,
    output logic        au_rst_n,
    input  logic [31:0] au_s,
    input  logic [31:0] au_hi,
    input  logic [31:0] au_lo,
    input  logic        au_zero
);

    localparam int MAX_CYC = (ADD_CYCLES > MD_CYCLES) ? ADD_CYCLES : MD_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [31:0]   au_a_q,      au_a_d;
    logic [31:0]   au_b_q,      au_b_d;
    logic [1:0]    au_op_q,     au_op_d;
    logic          au_rst_n_q,  au_rst_n_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_hi_q,    rsp_hi_d;
    logic [31:0]   rsp_lo_q,    rsp_lo_d;
    logic          rsp_zero_q,  rsp_zero_d;
    logic          rsp_err_q,   rsp_err_d;

    // Next-state and next-output computation; every output is registered so the
    // unit sees glitch-free operands, opcode and init strobe.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        au_a_d      = au_a_q;
        au_b_d      = au_b_q;
        au_op_d     = au_op_q;
        au_rst_n_d  = 1'b1;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    au_a_d      = req_a;
                    au_b_d      = req_b;
                    au_op_d     = req_op;
                    req_ready_d = 1'b0;
                    if (req_op == OP_DIV && req_b == 32'd0) begin
                        // Divide-by-zero is answered locally; the unit is never started.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_hi_d    = req_a;
                        rsp_lo_d    = 32'hFFFF_FFFF;
                        rsp_zero_d  = 1'b0;
                    end else if (!req_op[1]) begin
                        state_d = S_RUN;
                        cnt_d   = CW'(ADD_CYCLES);
                    end else begin
                        // Multi-cycle ops need the unit's hi/lo state cleared first.
                        state_d    = S_INIT;
                        au_rst_n_d = 1'b0;
                    end
                end
            end

            S_INIT: begin
                state_d = S_RUN;
                cnt_d   = CW'(MD_CYCLES);
            end

            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                // A count of zero cannot occur for legal parameters; treating it as
                // done keeps the FSM from stalling forever.
                if (cnt_q <= CW'(1)) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_zero_d  = au_zero;
                    if (!au_op_q[1]) begin
                        rsp_hi_d = 32'd0;
                        rsp_lo_d = au_s;
                    end else begin
                        rsp_hi_d = au_hi;
                        rsp_lo_d = au_lo;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset holds the unit in init and drops any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            au_a_q      <= 32'd0;
            au_b_q      <= 32'd0;
            au_op_q     <= 2'b00;
            au_rst_n_q  <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hi_q    <= 32'd0;
            rsp_lo_q    <= 32'd0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            au_a_q      <= au_a_d;
            au_b_q      <= au_b_d;
            au_op_q     <= au_op_d;
            au_rst_n_q  <= au_rst_n_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_err   = rsp_err_q;
    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_op     = au_op_q;
    assign au_rst_n  = au_rst_n_q;

endmodule

// File: tb/tb_au_driver.sv
// tb/tb_au_driver.sv - randomized self-checking bench for au_driver with a behavioural unit model
module tb_au_driver;

    localparam int ADD_CYCLES = 1;
    localparam int MD_CYCLES  = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic [1:0]  req_op = 2'b00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_hi, rsp_lo;
    logic        rsp_zero, rsp_err;
    logic [31:0] au_a, au_b;
    logic [1:0]  au_op;
    logic        au_rst_n;
    logic [31:0] au_s, au_hi, au_lo;
    logic        au_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    au_driver #(.ADD_CYCLES(ADD_CYCLES), .MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .au_a(au_a), .au_b(au_b), .au_op(au_op), .au_rst_n(au_rst_n),
        .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero)
    );

    // Behavioural arithmetic unit: add/sub immediate, mult/div valid only
    // MD_CYCLES cycles after the init pulse, garbage before that.
    int          md_cnt = 1000;
    logic [63:0] prod;
    logic        md_ok;

    always @(posedge clk) begin
        if (!au_rst_n) md_cnt <= 0;
        else if (md_cnt < 1000) md_cnt <= md_cnt + 1;
    end

    assign prod    = 64'(au_a) * 64'(au_b);
    assign md_ok   = (md_cnt >= MD_CYCLES - 1);
    assign au_s    = au_op[0] ? (au_a - au_b) : (au_a + au_b);
    assign au_hi   = !md_ok ? 32'hDEADBEEF :
                     (au_op == 2'b10) ? prod[63:32] : ((au_b == 0) ? 32'd0 : au_a % au_b);
    assign au_lo   = !md_ok ? 32'hBADC0FFE :
                     (au_op == 2'b10) ? prod[31:0] : ((au_b == 0) ? 32'd0 : au_a / au_b);
    assign au_zero = au_op[1] ? (md_ok ? (au_hi == 0 && au_lo == 0) : 1'b1) : (au_s == 0);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected response {hi, lo, zero, err} straight from the operation's arithmetic.
    function automatic logic [65:0] ref_rsp(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic [63:0] r;
        case (op)
            2'b00: r = {32'd0, a + b};
            2'b01: r = {32'd0, a - b};
            2'b10: r = 64'(a) * 64'(b);
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF, 1'b0, 1'b1};
                r = {a % b, a / b};
            end
        endcase
        return {r, (r == 64'd0), 1'b0};
    endfunction

    function automatic int ref_lat(input logic [31:0] b, input logic [1:0] op);
        if (op == 2'b11 && b == 0) return 1;
        if (!op[1]) return ADD_CYCLES + 1;
        return MD_CYCLES + 2;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", req_ready, 1);
    endtask

    // One full transaction: issue, measure latency and init pulse, check result,
    // apply backpressure for 'hold' cycles, then complete the handshake.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input int hold, input bit poke);
        logic [65:0] exp;
        int got_lat, low_cnt, low_lat;
        exp = ref_rsp(a, b, op);
        got_lat = 0; low_cnt = 0; low_lat = 0;
        @(negedge clk);
        wait_idle();
        req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = $urandom; req_b = $urandom;
        for (int k = 0; k < 100; k++) begin
            if (!au_rst_n) begin
                low_cnt++;
                low_lat = k + 1;
            end
            if (k == 0) chk("req_ready_busy", req_ready, 0);
            if (rsp_valid) begin
                got_lat = k + 1;
                break;
            end
            if (poke && k == 3) begin
                req_valid = 1'b1; req_a = ~a; req_b = ~b; req_op = ~op;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("latency", 64'(got_lat), 64'(ref_lat(b, op)));
        chk("init_pulses", 64'(low_cnt), (op[1] && !(op == 2'b11 && b == 0)) ? 64'd1 : 64'd0);
        if (low_cnt != 0) chk("init_cycle", 64'(low_lat), 64'd1);
        chk("au_operands", {au_a, au_b}, {a, b});
        chk("au_opcode", 64'(au_op), 64'(op));
        chk("rsp_hi_lo", {rsp_hi, rsp_lo}, exp[65:2]);
        chk("rsp_zero_err", {62'd0, rsp_zero, rsp_err}, {62'd0, exp[1:0]});
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            if (h == 0) begin
                req_valid = 1'b1; req_a = ~a; req_b = a ^ b; req_op = ~op;
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            chk("hold_data", {rsp_hi, rsp_lo}, exp[65:2]);
            chk("hold_ctrl", {60'd0, rsp_valid, req_ready, rsp_zero, rsp_err},
                {60'd0, 1'b1, 1'b0, exp[1:0]});
        end
        req_valid = 1'b0;
        if (hold > 0) chk("hold_operands", {au_a, au_b}, {a, b});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {62'd0, rsp_valid, req_ready}, 64'b01);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ctrl"}, {60'd0, rsp_valid, req_ready, au_rst_n, rsp_zero},
            {60'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        chk({tag, "_rsp"}, {rsp_hi, rsp_lo}, 64'd0);
        chk({tag, "_au"}, {au_a, au_b}, 64'd0);
        chk({tag, "_op_err"}, {61'd0, au_op, rsp_err}, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        int          seen;

        repeat (3) @(negedge clk);
        chk_reset_values("reset_init");
        rst = 1'b0;
        #1 chk("au_rst_n_before_edge", au_rst_n, 0);
        @(negedge clk);
        chk("au_rst_n_after_edge", au_rst_n, 1);

        run_op(32'd5, 32'd7, 2'b00, 0, 1'b0);
        run_op(32'd9, 32'd9, 2'b01, 0, 1'b0);
        run_op(32'd0, 32'd1, 2'b01, 1, 1'b0);
        run_op(32'h0001_0000, 32'h0001_0000, 2'b10, 0, 1'b1);
        run_op(32'd100, 32'd7, 2'b11, 5, 1'b1);
        run_op(32'd42, 32'd0, 2'b11, 2, 1'b0);

        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            run_op(a, b, op, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a MULT abandons it without a response.
        @(negedge clk);
        wait_idle();
        req_a = 32'd3; req_b = 32'd5; req_op = 2'b10; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_values("reset_async");
        @(negedge clk);
        chk("au_rst_n_in_reset", au_rst_n, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", {62'd0, au_rst_n, req_ready}, 64'b11);
        seen = 0;
        for (int k = 0; k < MD_CYCLES + 10; k++) begin
            if (rsp_valid) seen++;
            @(negedge clk);
        end
        chk("no_stale_rsp", 64'(seen), 64'd0);
        run_op(32'd1, 32'd1, 2'b00, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
